gpio_input_controller: RTL and testbench

Memory-mapped GPIO input port: the read-side counterpart of the GPIO output register on the data-memory bus. Samples GPIO_WIDTH external pins through a 2-flop synchronizer, optionally debounces them, and latches sticky rising-edge flags. The CPU reads the pin value and the edge flags via combinational rdata, and clears flags by write-1-to-clear. Sits beside the output GPIO on the same addr_ram/wdata/enable_sw bus; rdata feeds the load-data mux.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_in_debounce.sv | 44 ++++
 rtl/gpio_input_controller.sv | 113 +++++++++++
 tb/tb_gpio_input_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO register-map constants and decode types for the data-memory bus
// (output controller, input controller and address decoder).
package gpio_pkg;

    localparam logic [31:0] GPIO_OUT_ADDR         = 32'h1001_0024;
    localparam logic [31:0] GPIO_IN_DATA_ADDR     = 32'h1001_0028;
    localparam logic [31:0] GPIO_IN_STATUS_ADDR   = 32'h1001_002C;
    localparam int          GPIO_IN_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_DATA   = 2'd1,
        SEL_STATUS = 2'd2
    } gpio_in_sel_e;

endpackage

// File: rtl/gpio_in_debounce.sv
// Single-bit debouncer: 'stable' follows 'sample' only after DEBOUNCE_CYCLES
// consecutive samples that differ from the current stable value.
module gpio_in_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sample,
    output logic stable
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Any sample matching the stable value restarts the count, so glitches are dropped.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sample == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sample;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/gpio_input_controller.sv
// Memory-mapped GPIO input port: 2-flop synchronizer, optional debounce
// (define GPIO_IN_DEBOUNCE_EN), sticky rising-edge flags with W1C clear.
module gpio_input_controller
    import gpio_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    GPIO_WIDTH      = GPIO_IN_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDR       = ADDR_WIDTH'(GPIO_IN_DATA_ADDR),
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR     = ADDR_WIDTH'(GPIO_IN_STATUS_ADDR),
    parameter int                    DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_ram,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  enable_sw,
    input  logic [GPIO_WIDTH-1:0] gpio_data_in,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  irq
);

    if (GPIO_WIDTH > DATA_WIDTH || GPIO_WIDTH < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("gpio_input_controller: invalid GPIO_WIDTH/DATA_WIDTH/DEBOUNCE_CYCLES");
    end

    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q;
    logic [GPIO_WIDTH-1:0] pin_val;
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] flags_q, flags_d;
    logic [GPIO_WIDTH-1:0] rise;
    gpio_in_sel_e          sel;
    logic                  unused_wdata;

    // Only the low GPIO_WIDTH bits of a write carry clear masks.
    assign unused_wdata = ^(wdata >> GPIO_WIDTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_data_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_db
        gpio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .sample (sync2_q[i]),
            .stable (pin_val[i])
        );
    end
`else
    logic [GPIO_WIDTH-1:0] pin_val_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pin_val_q <= '0;
        end else begin
            pin_val_q <= sync2_q;
        end
    end

    assign pin_val = pin_val_q;
`endif

    always_comb begin
        sel = SEL_NONE;
        if (addr_ram == DATA_ADDR) begin
            sel = SEL_DATA;
        end else if (addr_ram == STATUS_ADDR) begin
            sel = SEL_STATUS;
        end
    end

    assign rise = pin_val & ~prev_q;

    // A new rising edge wins over a simultaneous clear of the same bit.
    always_comb begin
        flags_d = flags_q | rise;
        if (enable_sw && (sel == SEL_STATUS)) begin
            flags_d = (flags_q & ~wdata[GPIO_WIDTH-1:0]) | rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            flags_q <= '0;
        end else begin
            prev_q  <= pin_val;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            SEL_DATA:   rdata = DATA_WIDTH'(pin_val);
            SEL_STATUS: rdata = DATA_WIDTH'(flags_q);
            default:    rdata = '0;
        endcase
    end

    assign irq = |flags_q;

endmodule

// File: tb/tb_gpio_input_controller.sv
// Directed bench for gpio_input_controller; latencies follow GPIO_IN_DEBOUNCE_EN.
module tb_gpio_input_controller;

    localparam logic [31:0] A_DATA   = 32'h1001_0028;
    localparam logic [31:0] A_STATUS = 32'h1001_002C;
    localparam logic [31:0] A_OUT    = 32'h1001_0024;
    localparam logic [31:0] A_UNMAP  = 32'h1001_0030;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_ram;
    logic [31:0] wdata;
    logic        enable_sw;
    logic [7:0]  gpio_data_in;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    gpio_input_controller #(
        .DATA_WIDTH      (32),
        .ADDR_WIDTH      (32),
        .GPIO_WIDTH      (8),
        .DATA_ADDR       (A_DATA),
        .STATUS_ADDR     (A_STATUS),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_ram     (addr_ram),
        .wdata        (wdata),
        .enable_sw    (enable_sw),
        .gpio_data_in (gpio_data_in),
        .rdata        (rdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_ram = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr_ram  = a;
        wdata     = d;
        enable_sw = 1'b1;
        step(1);
        enable_sw = 1'b0;
        wdata     = '0;
    endtask

    initial begin
        reset        = 1'b1;
        addr_ram     = A_DATA;
        wdata        = '0;
        enable_sw    = 1'b0;
        gpio_data_in = 8'hA5;
        step(2);
        rd("reset_data", A_DATA, 32'h0);
        rd("reset_status", A_STATUS, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);

        // Pins high through reset release: value after LAT edges, flags one edge later.
        reset = 1'b0;
        step(LAT - 1);
        rd("rel_data_early", A_DATA, 32'h0);
        step(1);
        rd("rel_data", A_DATA, 32'h0000_00A5);
        rd("rel_status_early", A_STATUS, 32'h0);
        step(1);
        rd("rel_status", A_STATUS, 32'h0000_00A5);
        chk("rel_irq", {31'b0, irq}, 32'h1);

        wr(A_STATUS, 32'hFFFF_FF00);
        rd("w1c_upper_ignored", A_STATUS, 32'h0000_00A5);
        wr(A_STATUS, 32'h0000_00FF);
        rd("w1c_all", A_STATUS, 32'h0);
        chk("w1c_all_irq", {31'b0, irq}, 32'h0);

        gpio_data_in = 8'h00;
        step(LAT + 2);
        rd("fall_data", A_DATA, 32'h0);
        rd("fall_no_flag", A_STATUS, 32'h0);

        gpio_data_in = 8'h08;
        step(LAT + 1);
        rd("pin3_rise", A_STATUS, 32'h0000_0008);
        chk("pin3_irq", {31'b0, irq}, 32'h1);
        gpio_data_in = 8'h00;
        step(LAT + 2);
        rd("pin3_fall_data", A_DATA, 32'h0);
        rd("pin3_fall_sticky", A_STATUS, 32'h0000_0008);

        gpio_data_in = 8'h04;
        step(LAT + 1);
        rd("flags_0c", A_STATUS, 32'h0000_000C);
        wr(A_STATUS, 32'h0000_0004);
        rd("w1c_bit2", A_STATUS, 32'h0000_0008);
        chk("w1c_bit2_irq", {31'b0, irq}, 32'h1);
        wr(A_STATUS, 32'h0000_0008);
        rd("w1c_bit3", A_STATUS, 32'h0);
        chk("w1c_bit3_irq", {31'b0, irq}, 32'h0);

        // Clear of bit1 lands on the same edge that latches rise[1].
        gpio_data_in = 8'h06;
        step(LAT);
        wr(A_STATUS, 32'h0000_0002);
        rd("collision_set_wins", A_STATUS, 32'h0000_0002);
        wr(A_STATUS, 32'h0000_0002);
        rd("collision_cleared", A_STATUS, 32'h0);

        gpio_data_in = 8'h86;
        step(LAT + 1);
        rd("bit7_flag", A_STATUS, 32'h0000_0080);
        wr(A_DATA, 32'h0000_00FF);
        rd("wr_data_ignored", A_STATUS, 32'h0000_0080);
        wr(A_OUT, 32'h0000_00FF);
        rd("wr_out_ignored", A_STATUS, 32'h0000_0080);
        rd("unmapped_read", A_UNMAP, 32'h0);
        rd("data_86", A_DATA, 32'h0000_0086);

`ifdef GPIO_IN_DEBOUNCE_EN
        gpio_data_in = 8'h87;
        step(3);
        gpio_data_in = 8'h86;
        step(10);
        rd("glitch_data", A_DATA, 32'h0000_0086);
        rd("glitch_no_flag", A_STATUS, 32'h0000_0080);

        gpio_data_in = 8'h87;
        step(5);
        rd("db_bit0_early", A_DATA, 32'h0000_0086);
        step(1);
        rd("db_bit0_on_time", A_DATA, 32'h0000_0087);
        step(1);
        rd("db_bit0_flag", A_STATUS, 32'h0000_0081);

        // Reset during a pending change discards it.
        gpio_data_in = 8'h07;
        step(4);
        reset = 1'b1;
        step(1);
        reset        = 1'b0;
        gpio_data_in = 8'h00;
        step(LAT + 2);
        rd("db_reset_discard", A_DATA, 32'h0);
        gpio_data_in = 8'h80;
        step(LAT + 1);
`endif

        // Asynchronous reset must clear state without waiting for a clock edge.
        rd("pre_async_status", A_STATUS, 32'h0000_0080);
        reset = 1'b1;
        #1;
        chk("async_irq", {31'b0, irq}, 32'h0);
        rd("async_status", A_STATUS, 32'h0);
        rd("async_data", A_DATA, 32'h0);
        step(1);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
